// File: rtl/snake_tick_sequencer_pkg.sv
// Shared types for the snake game tick sequencer: state encodings, commit
// outcomes and default timing constants.
package snake_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_MOVE      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_COMMIT    = 3'd4,
    ST_RESPAWN   = 3'd5,
    ST_PAUSED    = 3'd6,
    ST_OVER      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OUT_MOVE    = 2'd0,
    OUT_GROW    = 2'd1,
    OUT_RESPAWN = 2'd2,
    OUT_OVER    = 2'd3
  } outcome_e;

  localparam int DEF_RESPAWN_TICKS  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_OVR_WIDTH      = 8;

  // A collision always outranks a fruit; the last life turns it fatal.
  function automatic outcome_e resolve_outcome(input logic coll_hit,
                                               input logic fruit_hit,
                                               input logic [2:0] lives);
    if (coll_hit) begin
      if (lives <= 3'd1) return OUT_OVER;
      return OUT_RESPAWN;
    end
    if (fruit_hit) return OUT_GROW;
    return OUT_MOVE;
  endfunction

endpackage

// File: rtl/snake_tick_sequencer_if.sv
// Handshake bundle between the tick sequencer and the snake datapath stages
// (movement, collision/fruit check, state-register commit).
interface snake_tick_sequencer_if;

  logic       new_game;
  logic       move_req;
  logic       move_done;
  logic       check_req;
  logic       coll_valid;
  logic       coll_hit;
  logic       fruit_hit;
  logic [2:0] lives;
  logic       commit_move;
  logic       commit_grow;
  logic       commit_respawn;

  modport master (
    output new_game, move_req, check_req, commit_move, commit_grow, commit_respawn,
    input  move_done, coll_valid, coll_hit, fruit_hit, lives
  );

  modport slave (
    input  new_game, move_req, check_req, commit_move, commit_grow, commit_respawn,
    output move_done, coll_valid, coll_hit, fruit_hit, lives
  );

endinterface

// File: rtl/snake_tick_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over increment.
module snake_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/snake_tick_sequencer.sv
// Sequences one snake update per game tick: move, then check, then a single
// commit strobe. Also owns pause, respawn freeze and game-over handling.
module snake_tick_sequencer
  import snake_ctrl_pkg::*;
#(
  parameter int RESPAWN_TICKS  = DEF_RESPAWN_TICKS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int OVR_WIDTH      = DEF_OVR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 btn_start,
  input  logic                 btn_pause,
  snake_tick_sequencer_if.master dp,
  output logic                 game_over,
  output logic                 paused,
  output logic [2:0]           state,
  output logic [OVR_WIDTH-1:0] tick_overrun,
  output logic                 hs_error
);

  localparam int FRZ_W = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS + 1);
  localparam logic [FRZ_W-1:0] FRZ_LOAD = FRZ_W'(RESPAWN_TICKS);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_d, state_q;
  state_e           ret_d, ret_q;
  outcome_e         outcome_d, outcome_q;
  logic [FRZ_W-1:0] frz_d, frz_q;
  logic             start_q;
  logic             pause_pend_d, pause_pend_q;
  logic             hs_error_d, hs_error_q;
  logic             new_game_d, new_game_q;
  logic             move_req_d, move_req_q;
  logic             check_req_d, check_req_q;
  logic             commit_move_d, commit_move_q;
  logic             commit_grow_d, commit_grow_q;
  logic             commit_respawn_d, commit_respawn_q;
  logic             game_over_d, game_over_q;
  logic             paused_d, paused_q;

  logic             start_rise;
  logic             in_hs;
  logic             busy;
  logic             tmo_hit;
  logic             tmo_clr;
  logic [TMO_W-1:0] tmo_cnt;

  assign start_rise = btn_start & ~start_q;
  assign in_hs      = (state_q == ST_MOVE) || (state_q == ST_CHECK);
  assign busy       = in_hs || (state_q == ST_COMMIT);
  assign tmo_hit    = in_hs && (tmo_cnt == TMO_LAST);
  assign tmo_clr    = !in_hs || (state_d != state_q);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    outcome_d    = outcome_q;
    frz_d        = frz_q;
    pause_pend_d = pause_pend_q;
    hs_error_d   = hs_error_q;
    new_game_d   = 1'b0;

    // Pauses arriving mid-update are deferred until the update has committed.
    if (busy && btn_pause) pause_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d      = ST_WAIT_TICK;
          new_game_d   = 1'b1;
          hs_error_d   = 1'b0;
          pause_pend_d = 1'b0;
        end
      end
      ST_WAIT_TICK: begin
        if (btn_pause || pause_pend_q) begin
          state_d      = ST_PAUSED;
          ret_d        = ST_WAIT_TICK;
          pause_pend_d = 1'b0;
        end else if (tick) begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (dp.move_done) begin
          state_d = ST_CHECK;
        end else if (tmo_hit) begin
          state_d    = ST_WAIT_TICK;
          hs_error_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (dp.coll_valid) begin
          outcome_d = resolve_outcome(dp.coll_hit, dp.fruit_hit, dp.lives);
          state_d   = ST_COMMIT;
        end else if (tmo_hit) begin
          state_d    = ST_WAIT_TICK;
          hs_error_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        case (outcome_q)
          OUT_OVER: state_d = ST_OVER;
          OUT_RESPAWN: begin
            if (RESPAWN_TICKS == 0) begin
              state_d = ST_WAIT_TICK;
            end else begin
              state_d = ST_RESPAWN;
              frz_d   = FRZ_LOAD;
            end
          end
          default: state_d = ST_WAIT_TICK;
        endcase
      end
      ST_RESPAWN: begin
        if (btn_pause) begin
          state_d = ST_PAUSED;
          ret_d   = ST_RESPAWN;
        end else if (tick) begin
          if (frz_q == FRZ_W'(1)) state_d = ST_WAIT_TICK;
          frz_d = frz_q - FRZ_W'(1);
        end
      end
      ST_PAUSED: begin
        if (btn_pause) state_d = ret_q;
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    move_req_d       = (state_d == ST_MOVE);
    check_req_d      = (state_d == ST_CHECK);
    commit_move_d    = (state_d == ST_COMMIT) && (outcome_d == OUT_MOVE);
    commit_grow_d    = (state_d == ST_COMMIT) && (outcome_d == OUT_GROW);
    commit_respawn_d = (state_d == ST_COMMIT) && (outcome_d == OUT_RESPAWN);
    game_over_d      = (state_d == ST_OVER);
    paused_d         = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ret_q            <= ST_IDLE;
      outcome_q        <= OUT_MOVE;
      frz_q            <= '0;
      start_q          <= 1'b0;
      pause_pend_q     <= 1'b0;
      hs_error_q       <= 1'b0;
      new_game_q       <= 1'b0;
      move_req_q       <= 1'b0;
      check_req_q      <= 1'b0;
      commit_move_q    <= 1'b0;
      commit_grow_q    <= 1'b0;
      commit_respawn_q <= 1'b0;
      game_over_q      <= 1'b0;
      paused_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      ret_q            <= ret_d;
      outcome_q        <= outcome_d;
      frz_q            <= frz_d;
      start_q          <= btn_start;
      pause_pend_q     <= pause_pend_d;
      hs_error_q       <= hs_error_d;
      new_game_q       <= new_game_d;
      move_req_q       <= move_req_d;
      check_req_q      <= check_req_d;
      commit_move_q    <= commit_move_d;
      commit_grow_q    <= commit_grow_d;
      commit_respawn_q <= commit_respawn_d;
      game_over_q      <= game_over_d;
      paused_q         <= paused_d;
    end
  end

  snake_sat_counter #(.WIDTH(OVR_WIDTH)) u_ovr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game_d),
    .inc   (busy && tick),
    .count (tick_overrun)
  );

  snake_sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .inc   (in_hs),
    .count (tmo_cnt)
  );

  assign dp.new_game       = new_game_q;
  assign dp.move_req       = move_req_q;
  assign dp.check_req      = check_req_q;
  assign dp.commit_move    = commit_move_q;
  assign dp.commit_grow    = commit_grow_q;
  assign dp.commit_respawn = commit_respawn_q;
  assign game_over         = game_over_q;
  assign paused            = paused_q;
  assign state             = state_q;
  assign hs_error          = hs_error_q;

endmodule

// File: tb/tb_snake_tick_sequencer.sv
// Directed bench for snake_tick_sequencer with a game-rule reference model;
// a second instance with a 2-bit overrun counter checks saturation.
module tb_snake_tick_sequencer;

  localparam int RESPAWN = 8;
  localparam int TIMEOUT = 255;
  localparam int S_IDLE = 0, S_WAIT = 1, S_MOVE = 2, S_CHECK = 3;
  localparam int S_COMMIT = 4, S_RESP = 5, S_PAUSE = 6, S_OVER = 7;

  logic       clk = 1'b0;
  logic       reset, tick, btn_start, btn_pause;
  logic       game_over, paused, hs_error;
  logic [2:0] state;
  logic [7:0] tick_overrun;
  logic       game_over2, paused2, hs_error2;
  logic [2:0] state2;
  logic [1:0] tick_overrun2;

  snake_tick_sequencer_if dp();
  snake_tick_sequencer_if dp2();

  assign dp2.move_done  = dp.move_done;
  assign dp2.coll_valid = dp.coll_valid;
  assign dp2.coll_hit   = dp.coll_hit;
  assign dp2.fruit_hit  = dp.fruit_hit;
  assign dp2.lives      = dp.lives;

  snake_tick_sequencer #(.RESPAWN_TICKS(RESPAWN), .TIMEOUT_CYCLES(TIMEOUT), .OVR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_pause(btn_pause),
    .dp(dp), .game_over(game_over), .paused(paused), .state(state),
    .tick_overrun(tick_overrun), .hs_error(hs_error)
  );

  snake_tick_sequencer #(.RESPAWN_TICKS(RESPAWN), .TIMEOUT_CYCLES(TIMEOUT), .OVR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_pause(btn_pause),
    .dp(dp2), .game_over(game_over2), .paused(paused2), .state(state2),
    .tick_overrun(tick_overrun2), .hs_error(hs_error2)
  );

  always #5 clk = ~clk;

  int  n_tests = 0, n_fail = 0;
  bit  chk_en = 1'b0;
  int  cnt_ng, cnt_mreq, cnt_cm, cnt_cg, cnt_cr;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: game rules evaluated once per clock from the sampled inputs.
  int m_state, m_ret, m_freeze, m_wait, m_outcome, m_nxt, e_ovr;
  bit m_pend, m_last_start, m_edge, e_new_game, e_cm, e_cg, e_cr, e_hs;

  always @(posedge clk) begin
    if (reset) begin
      m_state = S_IDLE; m_ret = S_IDLE; m_freeze = 0; m_wait = 0; m_outcome = 0;
      m_pend = 0; m_last_start = 0; e_new_game = 0; e_cm = 0; e_cg = 0; e_cr = 0;
      e_hs = 0; e_ovr = 0;
    end else begin
      m_edge = btn_start && !m_last_start;
      m_last_start = btn_start;
      e_new_game = 0; e_cm = 0; e_cg = 0; e_cr = 0;
      m_nxt = m_state;
      if (m_state == S_MOVE || m_state == S_CHECK || m_state == S_COMMIT) begin
        if (tick) e_ovr++;
        if (btn_pause) m_pend = 1;
      end
      if (m_state == S_MOVE || m_state == S_CHECK) m_wait++;
      case (m_state)
        S_IDLE: if (m_edge) begin
          m_nxt = S_WAIT; e_new_game = 1; e_ovr = 0; e_hs = 0; m_pend = 0;
        end
        S_WAIT: if (btn_pause || m_pend) begin
          m_nxt = S_PAUSE; m_ret = S_WAIT; m_pend = 0;
        end else if (tick) m_nxt = S_MOVE;
        S_MOVE: if (dp.move_done) m_nxt = S_CHECK;
                else if (m_wait >= TIMEOUT) begin m_nxt = S_WAIT; e_hs = 1; end
        S_CHECK: if (dp.coll_valid) begin
          if (dp.coll_hit && dp.lives <= 1) m_outcome = 3;
          else if (dp.coll_hit) m_outcome = 2;
          else if (dp.fruit_hit) m_outcome = 1;
          else m_outcome = 0;
          e_cm = (m_outcome == 0); e_cg = (m_outcome == 1); e_cr = (m_outcome == 2);
          m_nxt = S_COMMIT;
        end else if (m_wait >= TIMEOUT) begin m_nxt = S_WAIT; e_hs = 1; end
        S_COMMIT: begin
          if (m_outcome == 3) m_nxt = S_OVER;
          else if (m_outcome == 2 && RESPAWN > 0) begin m_nxt = S_RESP; m_freeze = RESPAWN; end
          else m_nxt = S_WAIT;
        end
        S_RESP: if (btn_pause) begin m_nxt = S_PAUSE; m_ret = S_RESP; end
                else if (tick) begin
                  m_freeze--;
                  if (m_freeze == 0) m_nxt = S_WAIT;
                end
        S_PAUSE: if (btn_pause) m_nxt = m_ret;
        default: if (m_edge) m_nxt = S_IDLE;
      endcase
      if (m_nxt != m_state) m_wait = 0;
      m_state = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("state", int'(state), m_state);
      checkOutput("new_game", int'(dp.new_game), int'(e_new_game));
      checkOutput("move_req", int'(dp.move_req), int'(m_state == S_MOVE));
      checkOutput("check_req", int'(dp.check_req), int'(m_state == S_CHECK));
      checkOutput("commit_move", int'(dp.commit_move), int'(e_cm));
      checkOutput("commit_grow", int'(dp.commit_grow), int'(e_cg));
      checkOutput("commit_respawn", int'(dp.commit_respawn), int'(e_cr));
      checkOutput("game_over", int'(game_over), int'(m_state == S_OVER));
      checkOutput("paused", int'(paused), int'(m_state == S_PAUSE));
      checkOutput("hs_error", int'(hs_error), int'(e_hs));
      checkOutput("tick_overrun", int'(tick_overrun), (e_ovr > 255) ? 255 : e_ovr);
      checkOutput("tick_overrun_w2", int'(tick_overrun2), (e_ovr > 3) ? 3 : e_ovr);
      checkOutput("state_w2", int'(state2), m_state);
    end
  end

  task automatic clearCounts();
    cnt_ng = 0; cnt_mreq = 0; cnt_cm = 0; cnt_cg = 0; cnt_cr = 0;
  endtask

  // Drives one clock of stimulus, then tallies the outputs that clock produced.
  task automatic applyStimulus(input logic t, input logic p, input logic md,
                               input logic cv, input logic ch, input logic fh);
    tick = t; btn_pause = p; dp.move_done = md;
    dp.coll_valid = cv; dp.coll_hit = ch; dp.fruit_hit = fh;
    @(negedge clk);
    tick = 0; btn_pause = 0; dp.move_done = 0; dp.coll_valid = 0; dp.coll_hit = 0; dp.fruit_hit = 0;
    cnt_ng   += int'(dp.new_game);
    cnt_mreq += int'(dp.move_req);
    cnt_cm   += int'(dp.commit_move);
    cnt_cg   += int'(dp.commit_grow);
    cnt_cr   += int'(dp.commit_respawn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;
    reset = 1; tick = 0; btn_start = 0; btn_pause = 0;
    dp.move_done = 0; dp.coll_valid = 0; dp.coll_hit = 0; dp.fruit_hit = 0; dp.lives = 3'd3;
    clearCounts();
    @(negedge clk);
    chk_en = 1;
    idle(2);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_move_req", int'(dp.move_req), 0);
    checkOutput("rst_overrun", int'(tick_overrun), 0);
    reset = 0;
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("idle_pause_ignored", int'(state), 0);

    clearCounts();
    btn_start = 1; idle(2); btn_start = 0;
    checkOutput("new_game_pulses", cnt_ng, 1);
    checkOutput("start_state", int'(state), 1);

    clearCounts();
    applyStimulus(1, 0, 0, 0, 0, 0); idle(2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); idle(1);
    checkOutput("plain_move_req_cycles", cnt_mreq, 3);
    checkOutput("plain_commit_move", cnt_cm, 1);
    checkOutput("plain_other_strobes", cnt_cg + cnt_cr, 0);
    checkOutput("plain_back_to_wait", int'(state), 1);

    clearCounts();
    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1); idle(1);
    checkOutput("fruit_commit_grow", cnt_cg, 1);
    checkOutput("fruit_no_move", cnt_cm + cnt_cr, 0);

    clearCounts();
    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1); idle(1);
    checkOutput("coll_commit_respawn", cnt_cr, 1);
    checkOutput("coll_no_grow", cnt_cg + cnt_cm, 0);
    checkOutput("coll_in_respawn", int'(state), 5);
    first = 0;
    for (int k = 1; k <= 12 && first == 0; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      if (dp.move_req) first = k; else idle(1);
    end
    checkOutput("respawn_ticks_to_move", first, 9);
    applyStimulus(0, 0, 1, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0, 0); idle(1);

    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(i == 5 || i == 15 || i == 25, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); idle(1);
    checkOutput("overrun_three", int'(tick_overrun), 3);
    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(i == 3 || i == 9 || i == 20 || i == 30, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0); idle(1);
    checkOutput("overrun_eight", int'(tick_overrun), 8);
    checkOutput("overrun_w2_saturated", int'(tick_overrun2), 3);

    clearCounts();
    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0, 0); idle(2);
    checkOutput("deferred_pause_commit", cnt_cm, 1);
    checkOutput("deferred_pause_state", int'(state), 6);
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 0, 0, 0, 0, 0); idle(1); end
    checkOutput("paused_ignores_ticks", int'(state), 6);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("unpause_to_wait", int'(state), 1);

    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0); idle(1);
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 0, 0, 0, 0, 0); idle(1); end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("respawn_pause_state", int'(state), 6);
    for (int i = 0; i < 2; i++) begin applyStimulus(1, 0, 0, 0, 0, 0); idle(1); end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("respawn_resume_state", int'(state), 5);
    first = 0;
    for (int k = 1; k <= 8 && first == 0; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      if (state == 3'd1) first = k; else idle(1);
    end
    checkOutput("respawn_resume_ticks_left", first, 5);

    applyStimulus(1, 0, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0, 0);
    btn_start = 1; dp.lives = 3'd1; clearCounts();
    applyStimulus(0, 0, 0, 1, 1, 0); idle(4);
    checkOutput("last_life_no_strobe", cnt_cm + cnt_cg + cnt_cr, 0);
    checkOutput("last_life_game_over", int'(game_over), 1);
    idle(3);
    checkOutput("held_start_stays_over", int'(state), 7);
    btn_start = 0; idle(2); btn_start = 1; idle(1);
    checkOutput("restart_to_idle", int'(state), 0);
    checkOutput("restart_game_over_low", int'(game_over), 0);
    btn_start = 0; dp.lives = 3'd3; idle(1);
    btn_start = 1; idle(1); btn_start = 0;
    checkOutput("new_game_clears_overrun", int'(tick_overrun), 0);

    clearCounts();
    applyStimulus(1, 0, 0, 0, 0, 0); idle(300);
    checkOutput("timeout_move_req_cycles", cnt_mreq, 255);
    checkOutput("timeout_hs_error", int'(hs_error), 1);
    checkOutput("timeout_no_commit", cnt_cm + cnt_cg + cnt_cr, 0);
    checkOutput("timeout_state", int'(state), 1);

    applyStimulus(1, 0, 0, 0, 0, 0); idle(3);
    checkOutput("pre_reset_in_move", int'(state), 2);
    reset = 1; idle(1);
    checkOutput("midmove_reset_state", int'(state), 0);
    checkOutput("midmove_reset_move_req", int'(dp.move_req), 0);
    checkOutput("midmove_reset_hs_error", int'(hs_error), 0);
    reset = 0; idle(2);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
